// File: rtl/hex_disp_pkg.sv
// Shared constants for the multiplexed hex display scanner: segment codes,
// the dark-segment pattern and a sizing helper.
package hex_disp_pkg;

   // Common-cathode {dp,g,f,e,d,c,b,a} codes for hex digits 0..F (dp clear).
   localparam logic [15:0][7:0] SEG_LUT = {
      8'h71, 8'h79, 8'h5e, 8'h39, 8'h7c, 8'h77, 8'h6f, 8'h7f,
      8'h07, 8'h7d, 8'h6d, 8'h66, 8'h4f, 8'h5b, 8'h06, 8'h3f
   };

   localparam logic [7:0] SEG_OFF = 8'h00;

   // Per-digit attributes carried from the scan stage to the output stage.
   typedef struct packed {
      logic [3:0] nib;
      logic       dp;
      logic       blank;
      logic       on;
   } slot_t;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/hex_scan_disp_if.sv
// Display-data bus between producers and the hex scanner, plus the pin-side
// Sel/Seg outputs and the frame reload strobe.
interface hex_scan_disp_if #(
   parameter int DIGITS = 8
);
   logic [4*DIGITS-1:0] Disp_data;
   logic [DIGITS-1:0]   Dp;
   logic [DIGITS-1:0]   Blank_mask;
   logic                Lz_en;
   logic [3:0]          Bright;
   logic [DIGITS-1:0]   Sel;
   logic [7:0]          Seg;
   logic                Frame_start;

   modport master (
      output Disp_data, Dp, Blank_mask, Lz_en, Bright,
      input  Sel, Seg, Frame_start
   );

   modport slave (
      input  Disp_data, Dp, Blank_mask, Lz_en, Bright,
      output Sel, Seg, Frame_start
   );
endinterface

// File: rtl/hex_scan_disp_seg7_decode.sv
// Hex nibble to active-high 7-segment pattern; blank darkens a..g only,
// the decimal point always follows dp.
module seg7_decode
   import hex_disp_pkg::*;
(
   input  logic [3:0] nibble,
   input  logic       dp,
   input  logic       blank,
   output logic [7:0] seg
);
   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      seg = SEG_OFF;
      if (!blank) seg = SEG_LUT[nibble];
      seg[7] = dp;
   end
endmodule

// File: rtl/hex_scan_disp.sv
// Multiplexed hex display scanner: slot divider, per-frame input shadow,
// leading-zero blanking, PWM brightness and a two-stage Sel/Seg pipeline.
module hex_scan_disp
   import hex_disp_pkg::*;
#(
   parameter int DIGITS      = 8,
   parameter int SCAN_DIV    = 50000,
   parameter bit SEL_ACT_LOW = 1'b0,
   parameter bit SEG_ACT_LOW = 1'b0
) (
   input  logic            Clk,
   input  logic            Reset_n,
   hex_scan_disp_if.slave  bus
);
   localparam int DIV_W = (clog2(SCAN_DIV) > 0) ? clog2(SCAN_DIV) : 1;
   localparam int IDX_W = (DIGITS > 1) ? clog2(DIGITS) : 1;
   localparam int STEP  = SCAN_DIV / 16;
   localparam logic [DIGITS-1:0] SEL_INV = SEL_ACT_LOW ? '1 : '0;
   localparam logic [7:0]        SEG_INV = SEG_ACT_LOW ? 8'hff : 8'h00;

   logic [DIV_W-1:0]    div_cnt;
   logic [IDX_W-1:0]    idx;
   logic                frame_ld;
   logic                tick;
   logic                idx_last;

   logic [4*DIGITS-1:0] data_sh, data_v;
   logic [DIGITS-1:0]   dp_sh, dp_v;
   logic [DIGITS-1:0]   bm_sh, bm_v;
   logic                lz_en_sh, lz_en_v;
   logic [3:0]          bright_sh, bright_v;

   logic [DIGITS-1:0]   lz_mask;
   logic [IDX_W-1:0]    pos;
   logic [DIV_W:0]      on_cnt;
   slot_t               slot_d, s1;
   logic [IDX_W-1:0]    s1_idx;
   logic [7:0]          seg_int;
   logic [DIGITS-1:0]   sel_int;
   logic [DIGITS-1:0]   sel_q;
   logic [7:0]          seg_q;

   assign tick     = (div_cnt == DIV_W'(SCAN_DIV - 1));
   assign idx_last = (idx == IDX_W'(DIGITS - 1));

   // frame_ld comes out of reset set so the first cycle loads a fresh snapshot.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         div_cnt  <= '0;
         idx      <= '0;
         frame_ld <= 1'b1;
      end else begin
         frame_ld <= tick && idx_last;
         if (tick) begin
            div_cnt <= '0;
            idx     <= idx_last ? '0 : idx + IDX_W'(1);
         end else begin
            div_cnt <= div_cnt + DIV_W'(1);
         end
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         data_sh   <= '0;
         dp_sh     <= '0;
         bm_sh     <= '0;
         lz_en_sh  <= 1'b0;
         bright_sh <= '0;
      end else if (frame_ld) begin
         data_sh   <= bus.Disp_data;
         dp_sh     <= bus.Dp;
         bm_sh     <= bus.Blank_mask;
         lz_en_sh  <= bus.Lz_en;
         bright_sh <= bus.Bright;
      end
   end

   // During the reload cycle the scan stage sees the incoming snapshot, so the
   // first digit of a frame never mixes old and new data.
   assign data_v   = frame_ld ? bus.Disp_data  : data_sh;
   assign dp_v     = frame_ld ? bus.Dp         : dp_sh;
   assign bm_v     = frame_ld ? bus.Blank_mask : bm_sh;
   assign lz_en_v  = frame_ld ? bus.Lz_en      : lz_en_sh;
   assign bright_v = frame_ld ? bus.Bright     : bright_sh;

   // NOTE: blocking '=' inside always_comb builds the MSB-down zero chain in order.
   always_comb begin
      logic run;
      lz_mask = '0;
      run     = lz_en_v;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         run        = run && (data_v[4*i +: 4] == 4'h0);
         lz_mask[i] = run;
      end
   end

   assign pos    = IDX_W'(DIGITS - 1) - idx;
   assign on_cnt = (DIV_W + 1)'((32'(bright_v) + 32'd1) * 32'(STEP));

   always_comb begin
      slot_d       = '0;
      slot_d.nib   = data_v[4*pos +: 4];
      slot_d.dp    = dp_v[pos] & ~bm_v[pos];
      slot_d.blank = bm_v[pos] | lz_mask[pos];
      slot_d.on    = ({1'b0, div_cnt} < on_cnt);
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         s1     <= '0;
         s1_idx <= '0;
      end else begin
         s1     <= slot_d;
         s1_idx <= idx;
      end
   end

   seg7_decode u_dec (
      .nibble (s1.nib),
      .dp     (s1.dp),
      .blank  (s1.blank),
      .seg    (seg_int)
   );

   assign sel_int = s1.on ? (DIGITS'(1) << s1_idx) : '0;

   // Sel and Seg share one register stage so the pins never see them skewed.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         sel_q <= SEL_INV;
         seg_q <= SEG_OFF ^ SEG_INV;
      end else begin
         sel_q <= sel_int ^ SEL_INV;
         seg_q <= seg_int ^ SEG_INV;
      end
   end

   assign bus.Sel         = sel_q;
   assign bus.Seg         = seg_q;
   assign bus.Frame_start = frame_ld & Reset_n;
endmodule

// File: tb/tb_hex_scan_disp.sv
// Directed bench for hex_scan_disp: two instances (active-high and active-low
// pins) sharing clock and reset, DIGITS=8, SCAN_DIV=32.
module tb_hex_scan_disp;
   logic Clk = 1'b0;
   logic Reset_n = 1'b0;
   always #5 Clk = ~Clk;

   hex_scan_disp_if #(.DIGITS(8)) bus_a ();
   hex_scan_disp_if #(.DIGITS(8)) bus_b ();

   hex_scan_disp #(.DIGITS(8), .SCAN_DIV(32), .SEL_ACT_LOW(1'b0), .SEG_ACT_LOW(1'b0)) dut_a (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .bus     (bus_a)
   );

   hex_scan_disp #(.DIGITS(8), .SCAN_DIV(32), .SEL_ACT_LOW(1'b1), .SEG_ACT_LOW(1'b1)) dut_b (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .bus     (bus_b)
   );

   int total = 0;
   int bad   = 0;
   logic [7:0] exp_seg [8];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic set_a(input logic [31:0] d, input logic [7:0] dp, input logic [7:0] bm,
                        input logic lz, input logic [3:0] br);
      bus_a.Disp_data  = d;
      bus_a.Dp         = dp;
      bus_a.Blank_mask = bm;
      bus_a.Lz_en      = lz;
      bus_a.Bright     = br;
   endtask

   task automatic set_exp(input logic [63:0] v);
      for (int j = 0; j < 8; j++) exp_seg[j] = v[63 - 8*j -: 8];
   endtask

   // Advance at negedges until Frame_start is seen, bounded.
   task automatic wait_frame(input string tag);
      int n;
      n = 0;
      while (bus_a.Frame_start !== 1'b1 && n < 600) begin
         @(negedge Clk);
         n++;
      end
      if (n >= 600) check({tag, " frame timeout"}, 32'd0, 32'd1);
   endtask

   // Called at the negedge of a Frame_start cycle; walks all eight slots.
   // chg_en swaps Disp_data partway through slot 3.
   task automatic scan_frame(input string tag, input int on_exp,
                             input bit chg_en, input logic [31:0] chg_data);
      int act;
      bit stable;
      logic [7:0] seg0;
      repeat (2) @(negedge Clk);
      for (int j = 0; j < 8; j++) begin
         seg0   = bus_a.Seg;
         act    = 0;
         stable = 1'b1;
         for (int k = 0; k < 32; k++) begin
            if (bus_a.Sel == (8'h01 << j)) act++;
            else if (bus_a.Sel != 8'h00) stable = 1'b0;
            if (bus_a.Seg != seg0) stable = 1'b0;
            if (chg_en && j == 3 && k == 10) bus_a.Disp_data = chg_data;
            @(negedge Clk);
         end
         check($sformatf("%s seg slot%0d", tag, j), 32'(seg0), 32'(exp_seg[j]));
         check($sformatf("%s sel on-count slot%0d", tag, j), act, on_exp);
         check($sformatf("%s slot%0d stable", tag, j), 32'(stable), 32'd1);
      end
   endtask

   initial begin
      int n;
      set_a(32'h1234_5678, 8'h00, 8'h00, 1'b0, 4'd15);
      bus_b.Disp_data  = 32'h1234_5678;
      bus_b.Dp         = 8'h01;
      bus_b.Blank_mask = 8'h00;
      bus_b.Lz_en      = 1'b0;
      bus_b.Bright     = 4'd15;

      // Reset state and first frame after release.
      repeat (3) @(negedge Clk);
      check("rst sel_a", 32'(bus_a.Sel), 32'h00);
      check("rst seg_a", 32'(bus_a.Seg), 32'h00);
      check("rst fs_a", 32'(bus_a.Frame_start), 32'd0);
      check("rst sel_b", 32'(bus_b.Sel), 32'hff);
      check("rst seg_b", 32'(bus_b.Seg), 32'hff);
      Reset_n = 1'b1;
      #1;
      check("first fs", 32'(bus_a.Frame_start), 32'd1);
      @(negedge Clk);
      check("fs one cycle", 32'(bus_a.Frame_start), 32'd0);
      check("sel idle c1", 32'(bus_a.Sel), 32'h00);
      @(negedge Clk);
      check("first sel_a", 32'(bus_a.Sel), 32'h01);
      check("first seg_a", 32'(bus_a.Seg), 32'h06);
      check("first sel_b", 32'(bus_b.Sel), 32'hfe);
      check("first seg_b", 32'(bus_b.Seg), 32'hf9);
      repeat (224) @(negedge Clk);
      check("b slot7 sel", 32'(bus_b.Sel), 32'h7f);
      check("b slot7 seg", 32'(bus_b.Seg), 32'h00);
      check("a slot7 sel", 32'(bus_a.Sel), 32'h80);

      // Full-brightness scan and frame period.
      wait_frame("t1");
      set_exp(64'h065b_4f66_6d7d_077f);
      scan_frame("t1", 32, 1'b0, 32'h0);
      wait_frame("period");
      @(negedge Clk);
      n = 1;
      while (bus_a.Frame_start !== 1'b1 && n < 600) begin
         @(negedge Clk);
         n++;
      end
      check("fs period", n, 256);

      // Leading-zero blanking on and off, then dp/blank interaction.
      set_a(32'h0000_00A0, 8'h00, 8'h00, 1'b1, 4'd15);
      wait_frame("lz on");
      set_exp(64'h0000_0000_0000_773f);
      scan_frame("lz on", 32, 1'b0, 32'h0);
      set_a(32'h0000_00A0, 8'h00, 8'h00, 1'b0, 4'd15);
      wait_frame("lz off");
      set_exp(64'h3f3f_3f3f_3f3f_773f);
      scan_frame("lz off", 32, 1'b0, 32'h0);
      set_a(32'h0000_00A0, 8'h86, 8'h02, 1'b1, 4'd15);
      wait_frame("dp blank");
      set_exp(64'h8000_0000_0080_003f);
      scan_frame("dp blank", 32, 1'b0, 32'h0);

      // Brightness duty.
      set_a(32'h89AB_CDEF, 8'h00, 8'h00, 1'b0, 4'd3);
      wait_frame("bright3");
      set_exp(64'h7f6f_777c_395e_7971);
      scan_frame("bright3", 8, 1'b0, 32'h0);
      bus_a.Bright = 4'd0;
      wait_frame("bright0");
      scan_frame("bright0", 2, 1'b0, 32'h0);

      // Mid-frame input change stays invisible until the next reload.
      set_a(32'h1234_5678, 8'h00, 8'h00, 1'b0, 4'd15);
      wait_frame("snap");
      set_exp(64'h065b_4f66_6d7d_077f);
      scan_frame("snap", 32, 1'b1, 32'hFEDC_BA98);
      check("snap new frame seg", 32'(bus_a.Seg), 32'h71);
      check("snap new frame sel", 32'(bus_a.Sel), 32'h01);

      // Asynchronous reset mid-slot, then restart.
      repeat (40) @(negedge Clk);
      #2;
      Reset_n = 1'b0;
      #1;
      check("async rst sel_a", 32'(bus_a.Sel), 32'h00);
      check("async rst seg_a", 32'(bus_a.Seg), 32'h00);
      check("async rst fs_a", 32'(bus_a.Frame_start), 32'd0);
      check("async rst sel_b", 32'(bus_b.Sel), 32'hff);
      check("async rst seg_b", 32'(bus_b.Seg), 32'hff);
      repeat (3) @(negedge Clk);
      Reset_n = 1'b1;
      #1;
      check("restart fs", 32'(bus_a.Frame_start), 32'd1);
      @(negedge Clk);
      check("restart sel c1", 32'(bus_a.Sel), 32'h00);
      @(negedge Clk);
      check("restart sel c2", 32'(bus_a.Sel), 32'h01);
      check("restart seg c2", 32'(bus_a.Seg), 32'h71);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
